lsu_data_memory: RTL and testbench
==================================

LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between acceptance and response (0..7).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid&req_ready at clk edge.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned, out-of-range or reserved-size request.
REQ-016 SHALL have port init_busy  output  1  memory clear in progress.

Function
REQ-017 SHALL implement FSM states INIT, IDLE, WAIT, RESP.
REQ-018 SHALL, in INIT, write zero to one word per cycle from index 0 upward, then go to IDLE after index DEPTH_WORDS-1 (DEPTH_WORDS cycles total).
REQ-019 SHALL drive req_ready=1 only in IDLE; init_busy=1 only in INIT.
REQ-020 SHALL, on acceptance, capture request, go to WAIT if WAIT_STATES>0 else RESP.
REQ-021 SHALL count WAIT_STATES cycles in WAIT, then enter RESP; response latency = WAIT_STATES+1 cycles after acceptance edge.
REQ-022 SHALL perform the store array write exactly once, on the WAIT->RESP or IDLE->RESP transition, only if no error.
REQ-023 SHALL update only addressed byte lanes: byte lane addr[1:0], half lanes {addr[1],0}+{0,1}, word all four.
REQ-024 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then return to IDLE.
REQ-025 SHALL flag rsp_err for word index addr[31:2]>=DEPTH_WORDS, req_size=11, or misalignment (see REQ-031).
REQ-026 SHALL NOT accept a new request in the cycle rsp_valid&rsp_ready occurs (no pass-through).
REQ-027 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-028 SHALL, on rst=0, immediately force state INIT, init index 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1.
REQ-029 SHALL, on reset mid-transaction, discard the pending request with no array write and no response.
REQ-030 SHALL restart the clear from index 0 if reset reasserts during INIT.

Configuration
REQ-031 SHALL, with DMEM_MISALIGN_TRAP_EN defined, flag rsp_err for half with addr[0]=1 or word with addr[1:0]!=0, and suppress writes.
REQ-032 SHALL, without DMEM_MISALIGN_TRAP_EN, force misaligned addresses aligned (half clears addr[0], word clears addr[1:0]) with no error.

Structure
REQ-033 SHALL place size encodings, FSM state enum and MAX_WAIT constant in shared package dmem_pkg.
REQ-034 SHALL use one sub-module dmem_byte_lane for store byte-enable/data shifting and load extraction/extension.

Verification
REQ-035 SHALL test reset release with DEPTH_WORDS=256: init_busy high exactly 256 cycles, req_ready rises next cycle, all words read 0.
REQ-036 SHALL test SW 0xDEADBEEF @0x10, then LB @0x13 -> 0xFFFFFFDE, LBU @0x13 -> 0x000000DE, LH @0x10 -> 0xFFFFBEEF.
REQ-037 SHALL test SB 0x5A @0x21 over word 0x11223344 -> LW @0x20 returns 0x11225A44.
REQ-038 SHALL test WAIT_STATES=3 with rsp_ready held 0 for 5 cycles: rsp_valid asserts 4 cycles after acceptance, data stable until rsp_ready.
REQ-039 SHALL test LW @0x402 (trap enabled) -> rsp_err=1, rdata 0; SW @0x400 with DEPTH_WORDS=256 -> rsp_err=1, no array change.
REQ-040 SHALL test rst=0 asserted during WAIT of a SW: no response, re-init clears memory, stored word reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the LSU data memory.
// Build option: DMEM_MISALIGN_TRAP_EN (see lsu_data_memory).
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    localparam int MAX_WAIT   = 7;
    localparam int WAIT_CNT_W = 3;

    // Byte offset inside the word after forcing natural alignment.
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] res;
        case (size)
            SIZE_BYTE: res = off;
            SIZE_HALF: res = {off[1], 1'b0};
            default:   res = 2'b00;
        endcase
        return res;
    endfunction

    // True when the offset is not naturally aligned for the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            SIZE_HALF: res = off[0];
            SIZE_WORD: res = |off;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering: store byte enables and data shift, load extraction
// and sign/zero extension. The offset is expected already aligned.
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] rshift;

    // Lane selection and extension for the current access.
    always_comb begin
        be     = 4'b0000;
        wword  = wdata << {offset, 3'b000};
        rshift = rword >> {offset, 3'b000};
        rdata  = '0;
        case (size)
            SIZE_BYTE: begin
                be    = 4'b0001 << offset;
                rdata = is_unsigned ? {24'h0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
            end
            SIZE_HALF: begin
                be    = 4'b0011 << offset;
                rdata = is_unsigned ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
            end
            SIZE_WORD: begin
                be    = 4'b1111;
                rdata = rshift;
            end
            default: begin
                be    = 4'b0000;
                rdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// LSU data memory: word array with byte/half/word loads and stores,
// a zero-fill sequence after reset and a fixed response latency.
// Build option: define DMEM_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors; otherwise they are silently aligned down.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_INIT | clearing one word per cycle, index 0 upward
//   ST_IDLE | ready to accept a request
//   ST_WAIT | counting wait states for the captured request
//   ST_RESP | response presented, held until rsp_ready
module lsu_data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_busy
);

    localparam int                    AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0]           DEPTH_L   = 30'(DEPTH_WORDS);
    localparam logic [AW-1:0]         LAST_IDX  = AW'(DEPTH_WORDS - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                state, state_nxt;
    logic [AW-1:0]         init_idx;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [31:0]           mem [DEPTH_WORDS];

    logic                  cap_we, cap_uns, cap_err;
    logic [1:0]            cap_size, cap_off;
    logic [AW-1:0]         cap_idx;
    logic [31:0]           cap_wdata;

    logic                  accept, enter_resp, wait_done, in_idle;
    logic                  req_err;
    logic [1:0]            req_off;

    logic                  cur_we, cur_uns, cur_err;
    logic [1:0]            cur_size, cur_off;
    logic [AW-1:0]         cur_idx;
    logic [31:0]           cur_wdata, cur_rword;

    logic [3:0]            lane_be;
    logic [31:0]           lane_wword, lane_rdata;
    logic                  init_we, store_we;

    assign accept    = req_valid && req_ready;
    assign wait_done = (wait_cnt == '0);
    assign in_idle   = (state == ST_IDLE);

    // Decode of the live request: error flag and aligned lane offset.
    always_comb begin
        req_err = (req_addr[31:2] >= DEPTH_L) || (req_size == SIZE_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
        req_err = req_err || is_misaligned(req_size, req_addr[1:0]);
`endif
        req_off = align_offset(req_size, req_addr[1:0]);
    end

    // With zero wait states the response is formed straight from the live
    // request, so the lane logic looks at the inputs while idle.
    always_comb begin
        cur_we    = in_idle ? req_we                : cap_we;
        cur_uns   = in_idle ? req_unsigned          : cap_uns;
        cur_err   = in_idle ? req_err               : cap_err;
        cur_size  = in_idle ? req_size              : cap_size;
        cur_off   = in_idle ? req_off               : cap_off;
        cur_idx   = in_idle ? req_addr[AW+1:2]      : cap_idx;
        cur_wdata = in_idle ? req_wdata             : cap_wdata;
        cur_rword = mem[cur_idx];
    end

    dmem_byte_lane u_lane (
        .size        (cur_size),
        .is_unsigned (cur_uns),
        .offset      (cur_off),
        .wdata       (cur_wdata),
        .rword       (cur_rword),
        .be          (lane_be),
        .wword       (lane_wword),
        .rdata       (lane_rdata)
    );

    assign init_we  = (state == ST_INIT) && rst;
    assign store_we = enter_resp && cur_we && !cur_err;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INIT;
        else      state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        init_busy  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                if (init_idx == LAST_IDX) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt  = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Clear index, wait counter, request capture and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_idx  <= '0;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_uns   <= 1'b0;
            cap_err   <= 1'b0;
            cap_size  <= 2'b00;
            cap_off   <= 2'b00;
            cap_idx   <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == ST_INIT) init_idx <= init_idx + 1'b1;
            if (accept) begin
                cap_we    <= req_we;
                cap_uns   <= req_unsigned;
                cap_err   <= req_err;
                cap_size  <= req_size;
                cap_off   <= req_off;
                cap_idx   <= req_addr[AW+1:2];
                cap_wdata <= req_wdata;
                wait_cnt  <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && !wait_done) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (enter_resp) begin
                rsp_rdata <= (cur_we || cur_err) ? '0 : lane_rdata;
                rsp_err   <= cur_err;
            end
        end
    end

    // Array writes: zero fill during clear, byte-enabled store on entry to RESP.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= '0;
        end else if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) mem[cur_idx][8*b +: 8] <= lane_wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: byte-array reference model, expected-response
// queue and an independent response monitor.
module tb_lsu_data_memory;

    localparam int DEPTH   = 256;
    localparam int TB_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, init_busy;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_b [DEPTH*4];
    int         checks = 0;
    int         errors = 0;
    bit         rdy_random = 1'b0;

    always #5 clk = ~clk;

    lsu_data_memory #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(TB_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_busy    (init_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;
    endtask

    // Reference behaviour: memory as a flat byte array.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
        int unsigned n, ea;
        logic [31:0] v;
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        er = (size == 2'd3) || ((addr >> 2) >= DEPTH);
        ea = addr;
        if (size != 2'd3) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if ((addr % n) != 0) er = 1'b1;
`else
            ea = addr - (addr % n);
`endif
        end
        rd = 32'h0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) mem_b[ea + i] = 8'(wdata >> (8*i));
            end else begin
                v = 32'h0;
                for (int i = 0; i < int'(n); i++) v = v | (32'(mem_b[ea + i]) << (8*i));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit use_exp, input logic [31:0] exp_rd, input logic exp_er);
        int n = 0;
        logic [31:0] mrd;
        logic mer;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0 required 1");
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        model_access(we, size, uns, addr, wdata, mrd, mer);
        e.rdata = use_exp ? exp_rd : mrd;
        e.err   = use_exp ? exp_er : mer;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (init_busy && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Response ready: random when enabled, updated just after each rising edge.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every presented response is compared with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b required no response", rsp_rdata, rsp_err);
                end else begin
                    e = exp_q[0];
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int cnt, lat;
        logic [1:0] sz;
        logic [31:0] ad;
        logic er_mis;
        logic [31:0] rd_mis;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        model_clear();

        #12;
        chk("reset_init_busy", 32'(init_busy), 32'd1);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        wait_init(cnt);
        chk("init_cycles", 32'(cnt), 32'd256);
        chk("ready_after_init", 32'(req_ready), 32'd1);

        rdy_random = 1'b1;
        for (int w = 0; w < DEPTH; w++) issue(1'b0, 2'd2, 1'b0, 32'(w*4), 32'h0, 1'b1, 32'h0, 1'b0);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h000000DE, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0);

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h11225A44, 1'b0);
        drain();

        rdy_random = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        chk("rsp_latency", 32'(lat), 32'(TB_WAIT + 1));
        repeat (5) @(negedge clk);
        chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        drain();
        rdy_random = 1'b1;

        issue(1'b0, 2'd2, 1'b0, 32'h402, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        // In-range misaligned word load: error with trapping, aligned read otherwise.
`ifdef DMEM_MISALIGN_TRAP_EN
        er_mis = 1'b1; rd_mis = 32'h0;
`else
        er_mis = 1'b0; rd_mis = 32'hDEADBEEF;
`endif
        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b1, rd_mis, er_mis);
        issue(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000CAFE, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b0, 32'h0, 1'b0);
        end
        drain();

        rdy_random = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_init_busy", 32'(init_busy), 32'd1);
        chk("midreset_req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("midreset_no_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        wait_init(cnt);
        chk("reinit_cycles", 32'(cnt), 32'd256);
        rdy_random = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
